// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the shared-ALU arbiter: opcode encodings, FSM state
// encoding and default datapath widths.
package alu_ctrl_pkg;

   localparam int DW_DEF  = 4;
   localparam int OPW_DEF = 2;

   localparam logic [1:0] OP_NAND = 2'd0;
   localparam logic [1:0] OP_AND  = 2'd1;
   localparam logic [1:0] OP_OR   = 2'd2;
   localparam logic [1:0] OP_XOR  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb_2.sv
// Two-way round-robin arbiter, purely combinational. On a tie the requester
// that did not win last time is granted; nothing is granted while disabled.
module rr_arb_2 (
   input  logic       i_en,
   input  logic       i_valid0,
   input  logic       i_valid1,
   input  logic       i_last_grant,
   output logic [1:0] o_gnt,
   output logic       o_gnt_id
);

   // grant selection: single valid wins, tie goes to the opposite of last grant
   always_comb begin
      o_gnt    = 2'b00;
      o_gnt_id = 1'b0;
      if (!i_en) begin
         o_gnt    = 2'b00;
         o_gnt_id = 1'b0;
      end else if (i_valid0 && i_valid1) begin
         if (i_last_grant) begin
            o_gnt    = 2'b01;
            o_gnt_id = 1'b0;
         end else begin
            o_gnt    = 2'b10;
            o_gnt_id = 1'b1;
         end
      end else if (i_valid0) begin
         o_gnt    = 2'b01;
         o_gnt_id = 1'b0;
      end else if (i_valid1) begin
         o_gnt    = 2'b10;
         o_gnt_id = 1'b1;
      end else begin
         o_gnt    = 2'b00;
         o_gnt_id = 1'b0;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational bitwise ALU between two valid/ready requesters.
// Optional ALU_GOLDEN_CHECK_EN adds an internal result check driving o_rsp_err.
module alu_share_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int OPW = OPW_DEF
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_req0_valid,
   output logic           o_req0_ready,
   input  logic [OPW-1:0] i_req0_op,
   input  logic [DW-1:0]  i_req0_op1,
   input  logic [DW-1:0]  i_req0_op2,
   input  logic           i_req1_valid,
   output logic           o_req1_ready,
   input  logic [OPW-1:0] i_req1_op,
   input  logic [DW-1:0]  i_req1_op1,
   input  logic [DW-1:0]  i_req1_op2,
   output logic [OPW-1:0] o_alu_sel,
   output logic [DW-1:0]  o_alu_op1,
   output logic [DW-1:0]  o_alu_op2,
   input  logic [DW-1:0]  i_alu_dat,
   output logic           o_rsp_valid,
   input  logic           i_rsp_ready,
   output logic           o_rsp_id,
   output logic [DW-1:0]  o_rsp_dat,
   output logic           o_rsp_err
);

   state_t         state_q, state_d;
   logic [OPW-1:0] op_q, op_d;
   logic [DW-1:0]  op1_q, op1_d;
   logic [DW-1:0]  op2_q, op2_d;
   logic           id_q, id_d;
   logic           last_grant_q, last_grant_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_id_q, rsp_id_d;
   logic [DW-1:0]  rsp_dat_q, rsp_dat_d;
   logic           rsp_err_q, rsp_err_d;

   logic [1:0]     gnt_s;
   logic           gnt_id_s;
   logic           arb_en_s;
   logic           accept_s;
   logic           golden_mis_s;

   // reset has priority, so no grant is offered while it is asserted
   assign arb_en_s = (state_q == S_IDLE) & ~i_rst;

   rr_arb_2 u_arb (
      .i_en         (arb_en_s),
      .i_valid0     (i_req0_valid),
      .i_valid1     (i_req1_valid),
      .i_last_grant (last_grant_q),
      .o_gnt        (gnt_s),
      .o_gnt_id     (gnt_id_s)
   );

   assign accept_s = gnt_s[0] | gnt_s[1];

`ifdef ALU_GOLDEN_CHECK_EN
   logic [DW-1:0] golden_s;

   // reference model of the external ALU, fed from the registered operands
   always_comb begin
      golden_s = '0;
      case (op_q)
         OP_NAND: golden_s = ~(op1_q & op2_q);
         OP_AND:  golden_s = op1_q & op2_q;
         OP_OR:   golden_s = op1_q | op2_q;
         OP_XOR:  golden_s = op1_q ^ op2_q;
         default: golden_s = '0;
      endcase
   end

   assign golden_mis_s = (golden_s != i_alu_dat);
`else
   assign golden_mis_s = 1'b0;
`endif

   // next-state and datapath capture for the IDLE/EXEC/RESP sequence
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d      = S_EXEC;
               id_d         = gnt_id_s;
               last_grant_d = gnt_id_s;
               if (gnt_id_s) begin
                  op_d  = i_req1_op;
                  op1_d = i_req1_op1;
                  op2_d = i_req1_op2;
               end else begin
                  op_d  = i_req0_op;
                  op1_d = i_req0_op1;
                  op2_d = i_req0_op2;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_dat_d   = i_alu_dat;
            rsp_err_d   = golden_mis_s;
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end else begin
               state_d     = S_RESP;
            end
         end
         default: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         op1_q        <= '0;
         op2_q        <= '0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign o_req0_ready = gnt_s[0];
   assign o_req1_ready = gnt_s[1];
   assign o_alu_sel    = op_q;
   assign o_alu_op1    = op1_q;
   assign o_alu_op2    = op2_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_id     = rsp_id_q;
   assign o_rsp_dat    = rsp_dat_q;
   assign o_rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table, arbitration, backpressure,
// mid-op reset, exhaustive opcode/operand sweep and injected ALU fault.
module tb_alu_share_arbiter;
   import alu_ctrl_pkg::*;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_req0_valid, o_req0_ready;
   logic [1:0] i_req0_op;
   logic [3:0] i_req0_op1, i_req0_op2;
   logic       i_req1_valid, o_req1_ready;
   logic [1:0] i_req1_op;
   logic [3:0] i_req1_op1, i_req1_op2;
   logic [1:0] o_alu_sel;
   logic [3:0] o_alu_op1, o_alu_op2, i_alu_dat;
   logic       o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_err;
   logic [3:0] o_rsp_dat;
   logic       fault_en;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       port;
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp;
   } vec_t;
   vec_t vt[8];

   always #5 i_clk = ~i_clk;

   function automatic logic [3:0] gold(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         2'd0:    gold = ~(a & b);
         2'd1:    gold = a & b;
         2'd2:    gold = a | b;
         default: gold = a ^ b;
      endcase
   endfunction

   // external ALU stand-in, with a bit-0 fault that can be switched on
   assign i_alu_dat = gold(o_alu_sel, o_alu_op1, o_alu_op2) ^ {3'b000, fault_en};

   alu_share_arbiter dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
      .i_req0_op(i_req0_op), .i_req0_op1(i_req0_op1), .i_req0_op2(i_req0_op2),
      .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
      .i_req1_op(i_req1_op), .i_req1_op1(i_req1_op1), .i_req1_op2(i_req1_op2),
      .o_alu_sel(o_alu_sel), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
      .i_alu_dat(i_alu_dat),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_id(o_rsp_id), .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_ready();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (o_req0_ready || o_req1_ready) ok = 1'b1;
         else step();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_ready act=timeout exp=ready");
      end
   endtask

   task automatic do_op(input logic port, input logic [1:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] exp, input logic exp_err,
                        input string nm);
      i_rsp_ready = 1'b1;
      if (port) begin
         i_req1_valid = 1'b1; i_req1_op = op; i_req1_op1 = a; i_req1_op2 = b;
         i_req0_valid = 1'b0;
      end else begin
         i_req0_valid = 1'b1; i_req0_op = op; i_req0_op1 = a; i_req0_op2 = b;
         i_req1_valid = 1'b0;
      end
      #1;
      wait_ready();
      chk({nm, " ready"}, {14'd0, o_req1_ready, o_req0_ready}, port ? 16'd2 : 16'd1);
      step();
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      chk({nm, " exec_quiet"}, {13'd0, o_rsp_valid, o_req1_ready, o_req0_ready}, 16'd0);
      chk({nm, " alu_drive"}, {6'd0, o_alu_sel, o_alu_op1, o_alu_op2}, {6'd0, op, a, b});
      step();
      chk({nm, " rsp"}, {8'd0, o_rsp_valid, o_rsp_id, o_rsp_err, 1'b0, o_rsp_dat},
          {8'd0, 1'b1, port, exp_err, 1'b0, exp});
      step();
      chk({nm, " rsp_drop"}, {15'd0, o_rsp_valid}, 16'd0);
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      step();
      step();
      i_rst = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_err;
      vt[0] = '{1'b0, OP_NAND, 4'hC, 4'hA, 4'h7};
      vt[1] = '{1'b1, OP_AND,  4'hF, 4'h3, 4'h3};
      vt[2] = '{1'b0, OP_OR,   4'h1, 4'h8, 4'h9};
      vt[3] = '{1'b1, OP_XOR,  4'h5, 4'hF, 4'hA};
      vt[4] = '{1'b0, OP_NAND, 4'h0, 4'h0, 4'hF};
      vt[5] = '{1'b1, OP_XOR,  4'hF, 4'hF, 4'h0};
      vt[6] = '{1'b1, OP_NAND, 4'hF, 4'hF, 4'h0};
      vt[7] = '{1'b0, OP_AND,  4'hA, 4'h5, 4'h0};

      i_rst = 1'b1; fault_en = 1'b0; i_rsp_ready = 1'b1;
      i_req0_valid = 1'b0; i_req0_op = 2'd0; i_req0_op1 = 4'h0; i_req0_op2 = 4'h0;
      i_req1_valid = 1'b0; i_req1_op = 2'd0; i_req1_op1 = 4'h0; i_req1_op2 = 4'h0;
      step();
      step();
      chk("reset_ctrl", {11'd0, o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id, o_rsp_err}, 16'd0);
      chk("reset_dat", {12'd0, o_rsp_dat}, 16'd0);
      chk("reset_alu", {6'd0, o_alu_sel, o_alu_op1, o_alu_op2}, 16'd0);
      i_rst = 1'b0;
      step();
      chk("idle_ctrl", {12'd0, o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_err}, 16'd0);

      for (int i = 0; i < 8; i++)
         do_op(vt[i].port, vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 1'b0, $sformatf("vec%0d", i));

      // both requesters held valid: grants must alternate starting with req0
      do_reset();
      i_req0_valid = 1'b1; i_req0_op = OP_AND; i_req0_op1 = 4'hF; i_req0_op2 = 4'h3;
      i_req1_valid = 1'b1; i_req1_op = OP_XOR; i_req1_op1 = 4'h5; i_req1_op2 = 4'hF;
      #1;
      for (int k = 0; k < 4; k++) begin
         wait_ready();
         chk($sformatf("rr_grant%0d", k), {14'd0, o_req1_ready, o_req0_ready},
             (k % 2 == 1) ? 16'd2 : 16'd1);
         step();
         step();
         chk($sformatf("rr_rsp%0d", k), {10'd0, o_rsp_valid, o_rsp_id, o_rsp_dat},
             (k % 2 == 1) ? {10'd0, 1'b1, 1'b1, 4'hA} : {10'd0, 1'b1, 1'b0, 4'h3});
         step();
      end
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      step();

      // response backpressure for five cycles with a competing request pending
      i_rsp_ready = 1'b0;
      i_req0_valid = 1'b1; i_req0_op = OP_XOR; i_req0_op1 = 4'h6; i_req0_op2 = 4'h3;
      #1;
      wait_ready();
      chk("bp_ready", {14'd0, o_req1_ready, o_req0_ready}, 16'd1);
      step();
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b1; i_req1_op = OP_AND; i_req1_op1 = 4'hF; i_req1_op2 = 4'hF;
      step();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_hold%0d", i),
             {8'd0, o_rsp_valid, o_rsp_id, o_req1_ready, o_req0_ready, o_rsp_dat},
             {8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5});
         step();
      end
      i_rsp_ready = 1'b1;
      i_req1_valid = 1'b0;
      #1;
      chk("bp_last", {11'd0, o_rsp_valid, o_rsp_dat}, {11'd0, 1'b1, 4'h5});
      step();
      chk("bp_done", {15'd0, o_rsp_valid}, 16'd0);

      // reset during EXEC of a req1 op discards it; next tie goes to req0
      i_req1_valid = 1'b1; i_req1_op = OP_OR; i_req1_op1 = 4'h1; i_req1_op2 = 4'h8;
      #1;
      wait_ready();
      chk("rst_acc", {14'd0, o_req1_ready, o_req0_ready}, 16'd2);
      step();
      i_req1_valid = 1'b0;
      chk("rst_exec_alu", {6'd0, o_alu_sel, o_alu_op1, o_alu_op2}, {6'd0, OP_OR, 4'h1, 4'h8});
      i_rst = 1'b1;
      i_req0_valid = 1'b1; i_req0_op = OP_NAND; i_req0_op1 = 4'hC; i_req0_op2 = 4'hA;
      #1;
      chk("rst_no_ready", {14'd0, o_req1_ready, o_req0_ready}, 16'd0);
      step();
      i_rst = 1'b0;
      i_req1_valid = 1'b1;
      #1;
      chk("rst_after", {12'd0, o_rsp_valid, o_rsp_err, o_req1_ready, o_req0_ready}, 16'd1);
      chk("rst_alu", {6'd0, o_alu_sel, o_alu_op1, o_alu_op2}, 16'd0);
      step();
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      chk("rst_exec_quiet", {15'd0, o_rsp_valid}, 16'd0);
      step();
      chk("rst_next_rsp", {10'd0, o_rsp_valid, o_rsp_id, o_rsp_dat}, {10'd0, 1'b1, 1'b0, 4'h7});
      step();

      for (int op = 0; op < 4; op++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               do_op(1'b0, 2'(op), 4'(a), 4'(b), gold(2'(op), 4'(a), 4'(b)), 1'b0, "sweep");

      // corrupted ALU bit 0: result passes through, error flag only with the check built
`ifdef ALU_GOLDEN_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      fault_en = 1'b1;
      do_op(1'b0, OP_OR, 4'h0, 4'h0, 4'h1, exp_err, "golden");
      fault_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
